// File: rtl/pe_sequencer.sv
// PE job sequencer: steps a processing element through clear, scratchpad fill,
// compute, optional psum merge and scratchpad release for a grid of
// weight-by-iact passes. Abort returns to idle through a one-cycle clear state.
module pe_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_weight_passes,
  input  logic [CNT_W-1:0] cfg_iact_passes,
  input  logic [4:0]       cfg_psum_depth,
  input  logic             cfg_accumulate,
  input  logic             all_write_fin,
  input  logic             cal_fin,
  input  logic             psum_add_fin,
  output logic             do_load_en,
  output logic             psum_enq_en,
  output logic             iact_write_fin_clear,
  output logic             weight_write_fin_clear,
  output logic             psum_spad_clear,
  output logic [4:0]       PSUM_DEPTH,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] weight_pass_cnt,
  output logic [CNT_W-1:0] iact_pass_cnt
);

  typedef enum logic [3:0] {
    StIdle, StClear, StWaitWr, StLoad, StCompute, StAccum, StRelease, StDone, StAbort
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] weight_passes_q, weight_passes_d;
  logic [CNT_W-1:0] iact_passes_q, iact_passes_d;
  logic [CNT_W-1:0] weight_cnt_q, weight_cnt_d;
  logic [CNT_W-1:0] iact_cnt_q, iact_cnt_d;
  logic             accumulate_q, accumulate_d;
  logic [4:0]       psum_depth_q, psum_depth_d;
  logic             take_start, take_abort, weight_last, iact_last;

  assign take_start  = (state_q == StIdle) && start;
  // StAbort already heads to idle, so a held abort does not re-enter it
  assign take_abort  = abort && (state_q != StIdle) && (state_q != StAbort);
  assign weight_last = (weight_cnt_q == weight_passes_q - CNT_W'(1));
  assign iact_last   = (iact_cnt_q == iact_passes_q - CNT_W'(1));

  assign PSUM_DEPTH      = psum_depth_q;
  assign weight_pass_cnt = weight_cnt_q;
  assign iact_pass_cnt   = iact_cnt_q;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      weight_passes_q <= '0;
      iact_passes_q   <= '0;
      weight_cnt_q    <= '0;
      iact_cnt_q      <= '0;
      accumulate_q    <= 1'b0;
      psum_depth_q    <= '0;
    end else begin
      state_q         <= state_d;
      weight_passes_q <= weight_passes_d;
      iact_passes_q   <= iact_passes_d;
      weight_cnt_q    <= weight_cnt_d;
      iact_cnt_q      <= iact_cnt_d;
      accumulate_q    <= accumulate_d;
      psum_depth_q    <= psum_depth_d;
    end
  end

  // Next-state: abort overrides every transition out of a busy state
  always_comb begin
    state_d = state_q;
    if (take_abort) begin
      state_d = StAbort;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // zero passes means nothing to do: report completion directly
            state_d = ((cfg_weight_passes == '0) || (cfg_iact_passes == '0)) ? StDone : StClear;
          end
        end
        StClear:   state_d = StWaitWr;
        StWaitWr:  if (all_write_fin) state_d = StLoad;
        StLoad:    state_d = StCompute;
        StCompute: if (cal_fin) state_d = accumulate_q ? StAccum : StRelease;
        StAccum:   if (psum_add_fin) state_d = StRelease;
        StRelease: state_d = (weight_last && iact_last) ? StDone : StWaitWr;
        StDone:    state_d = StIdle;
        StAbort:   state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Config latch and pass counters
  always_comb begin
    weight_passes_d = weight_passes_q;
    iact_passes_d   = iact_passes_q;
    accumulate_d    = accumulate_q;
    psum_depth_d    = psum_depth_q;
    weight_cnt_d    = weight_cnt_q;
    iact_cnt_d      = iact_cnt_q;
    if (take_start) begin
      weight_passes_d = cfg_weight_passes;
      iact_passes_d   = cfg_iact_passes;
      accumulate_d    = cfg_accumulate;
      psum_depth_d    = cfg_psum_depth;
    end
    if (take_abort || (state_q == StDone)) begin
      weight_cnt_d = '0;
      iact_cnt_d   = '0;
    end else if (state_q == StRelease) begin
      if (weight_last) begin
        weight_cnt_d = '0;
        iact_cnt_d   = iact_cnt_q + CNT_W'(1);
      end else begin
        weight_cnt_d = weight_cnt_q + CNT_W'(1);
      end
    end
  end

  // Control outputs decoded from the current state
  always_comb begin
    do_load_en             = 1'b0;
    psum_enq_en            = 1'b0;
    iact_write_fin_clear   = 1'b0;
    weight_write_fin_clear = 1'b0;
    psum_spad_clear        = 1'b0;
    done                   = 1'b0;
    busy                   = (state_q != StIdle);
    unique case (state_q)
      StClear:   psum_spad_clear = 1'b1;
      StLoad:    do_load_en = 1'b1;
      StAccum:   psum_enq_en = 1'b1;
      StRelease: begin
        weight_write_fin_clear = 1'b1;
        iact_write_fin_clear   = weight_last;
      end
      StDone:    done = 1'b1;
      StAbort: begin
        iact_write_fin_clear   = 1'b1;
        weight_write_fin_clear = 1'b1;
        psum_spad_clear        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: a small PE model answers do_load_en and
// psum_enq_en, and a scoreboard of expected output events is checked in order.
module tb_pe_sequencer;

  localparam int unsigned CNT_W = 8;
  localparam int EvClear = 0;
  localparam int EvLoad  = 1;
  localparam int EvRel   = 2;
  localparam int EvDone  = 3;
  localparam int EvAbort = 4;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic             clock, reset, start, abort;
  logic [CNT_W-1:0] cfg_weight_passes, cfg_iact_passes;
  logic [4:0]       cfg_psum_depth;
  logic             cfg_accumulate, all_write_fin, cal_fin, psum_add_fin;
  logic             do_load_en, psum_enq_en, iact_write_fin_clear, weight_write_fin_clear;
  logic             psum_spad_clear, busy, done;
  logic [4:0]       PSUM_DEPTH;
  logic [CNT_W-1:0] weight_pass_cnt, iact_pass_cnt;

  ev_t exp_q[$];
  int  n_cmp, n_err, done_cnt, load_cnt, enq_run, enq_runs, exp_enq_len;
  int  cal_t, add_t, cal_delay, add_delay;
  bit  model_en, enq_prev;

  pe_sequencer #(.CNT_W(CNT_W)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .abort                  (abort),
    .cfg_weight_passes      (cfg_weight_passes),
    .cfg_iact_passes        (cfg_iact_passes),
    .cfg_psum_depth         (cfg_psum_depth),
    .cfg_accumulate         (cfg_accumulate),
    .all_write_fin          (all_write_fin),
    .cal_fin                (cal_fin),
    .psum_add_fin           (psum_add_fin),
    .do_load_en             (do_load_en),
    .psum_enq_en            (psum_enq_en),
    .iact_write_fin_clear   (iact_write_fin_clear),
    .weight_write_fin_clear (weight_write_fin_clear),
    .psum_spad_clear        (psum_spad_clear),
    .PSUM_DEPTH             (PSUM_DEPTH),
    .busy                   (busy),
    .done                   (done),
    .weight_pass_cnt        (weight_pass_cnt),
    .iact_pass_cnt          (iact_pass_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int a, input int b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  // Expected event stream for a complete job
  task automatic plan_job(input int w, input int i);
    if (w == 0 || i == 0) begin
      push(EvDone, 0, 0);
    end else begin
      push(EvClear, 0, 0);
      for (int ii = 0; ii < i; ii++) begin
        for (int ww = 0; ww < w; ww++) begin
          push(EvLoad, ii, ww);
          push(EvRel, (ww == w - 1) ? 1 : 0, 0);
        end
      end
      push(EvDone, 0, 0);
    end
  endtask

  task automatic sb_check(input int k, input int a, input int b);
    ev_t e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL sb_unexpected observed=event%0d expected=none", k);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_kind", k, e.kind);
      chk("sb_a", a, e.a);
      chk("sb_b", b, e.b);
    end
  endtask

  // One clock: observe outputs after the edge, check events, drive the PE model
  task automatic step();
    @(posedge clock);
    #1;
    if (psum_spad_clear && weight_write_fin_clear && iact_write_fin_clear) begin
      sb_check(EvAbort, 0, 0);
    end else begin
      if (psum_spad_clear) sb_check(EvClear, 0, 0);
      if (do_load_en) sb_check(EvLoad, int'(iact_pass_cnt), int'(weight_pass_cnt));
      if (weight_write_fin_clear) sb_check(EvRel, int'(iact_write_fin_clear), 0);
      else if (iact_write_fin_clear) chk("lone_iact_clr", 32'(iact_write_fin_clear), 0);
      if (done) sb_check(EvDone, 0, 0);
    end
    if (done) done_cnt++;
    if (do_load_en) load_cnt++;
    if (psum_enq_en) begin
      enq_run++;
    end else begin
      if (enq_run != 0 && exp_enq_len != 0) begin
        chk("enq_len", enq_run, exp_enq_len);
        enq_runs++;
      end
      enq_run = 0;
    end
    if (model_en) begin
      if (do_load_en) begin
        cal_t   = cal_delay;
        cal_fin = 1'b0;
      end else if (cal_t > 0) begin
        cal_t--;
        cal_fin = (cal_t == 0);
      end else begin
        cal_fin = 1'b0;
      end
      if (psum_enq_en && !enq_prev) begin
        add_t        = add_delay - 1;
        psum_add_fin = (add_t == 0);
      end else if (add_t > 0) begin
        add_t--;
        psum_add_fin = (add_t == 0);
      end else begin
        psum_add_fin = 1'b0;
      end
    end
    enq_prev = psum_enq_en;
  endtask

  task automatic start_job(input int w, input int i, input bit acc, input int depth,
                           input bit do_plan);
    cfg_weight_passes = CNT_W'(w);
    cfg_iact_passes   = CNT_W'(i);
    cfg_accumulate    = acc;
    cfg_psum_depth    = 5'(depth);
    if (do_plan) plan_job(w, i);
    cal_t = 0;
    add_t = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int d0, l0;
    n_cmp = 0; n_err = 0; done_cnt = 0; load_cnt = 0;
    enq_run = 0; enq_runs = 0; exp_enq_len = 0;
    cal_t = 0; add_t = 0; cal_delay = 3; add_delay = 4;
    model_en = 1'b1; enq_prev = 1'b0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_weight_passes = '0; cfg_iact_passes = '0; cfg_psum_depth = '0; cfg_accumulate = 1'b0;
    all_write_fin = 1'b0; cal_fin = 1'b0; psum_add_fin = 1'b0;

    // Reset state, with start and abort asserted to prove reset wins
    step();
    start = 1'b1; abort = 1'b1;
    repeat (2) step();
    chk("rst_ctrl", 32'({do_load_en, psum_enq_en, iact_write_fin_clear,
        weight_write_fin_clear, psum_spad_clear, busy, done}), 0);
    chk("rst_depth", 32'(PSUM_DEPTH), 0);
    chk("rst_wcnt", 32'(weight_pass_cnt), 0);
    chk("rst_icnt", 32'(iact_pass_cnt), 0);
    start = 1'b0; abort = 1'b0;
    reset = 1'b0;
    step();

    // Two weight passes, one iact pass, no accumulate
    all_write_fin = 1'b1;
    d0 = done_cnt;
    start_job(2, 1, 1'b0, 9, 1'b1);
    wait_idle(200);
    chk("t1_drain", exp_q.size(), 0);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_wcnt", 32'(weight_pass_cnt), 0);
    chk("t1_icnt", 32'(iact_pass_cnt), 0);
    chk("t1_depth", 32'(PSUM_DEPTH), 9);

    // Three iact passes with psum merge of four cycles each
    exp_enq_len = 4;
    enq_runs = 0;
    d0 = done_cnt;
    start_job(1, 3, 1'b1, 3, 1'b1);
    wait_idle(300);
    chk("t2_drain", exp_q.size(), 0);
    chk("t2_enq_runs", enq_runs, 3);
    chk("t2_done", done_cnt - d0, 1);
    exp_enq_len = 0;

    // Zero iact passes: done with no work
    d0 = done_cnt;
    l0 = load_cnt;
    start_job(5, 0, 1'b0, 1, 1'b1);
    step();
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_loads", load_cnt - l0, 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_drain", exp_q.size(), 0);

    // Abort while computing
    cal_delay = 20;
    d0 = done_cnt;
    push(EvClear, 0, 0);
    push(EvLoad, 0, 0);
    push(EvAbort, 0, 0);
    l0 = load_cnt;
    start_job(2, 2, 1'b0, 4, 1'b0);
    begin
      int n;
      n = 0;
      while (load_cnt == l0 && n < 20) begin
        step();
        n++;
      end
    end
    chk("t4_reach_load", load_cnt - l0, 1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_clr", 32'({iact_write_fin_clear, weight_write_fin_clear, psum_spad_clear}), 7);
    step();
    chk("t4_idle", 32'(busy), 0);
    chk("t4_clr_off", 32'({iact_write_fin_clear, weight_write_fin_clear, psum_spad_clear}), 0);
    chk("t4_cnts", 32'({weight_pass_cnt, iact_pass_cnt}), 0);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_drain", exp_q.size(), 0);
    cal_delay = 3;
    start_job(1, 1, 1'b0, 2, 1'b1);
    wait_idle(200);
    chk("t4_rerun_done", done_cnt - d0, 1);
    chk("t4_rerun_drain", exp_q.size(), 0);

    // Reset while accumulating; late completions must be ignored
    add_delay = 1000;
    d0 = done_cnt;
    push(EvClear, 0, 0);
    push(EvLoad, 0, 0);
    start_job(1, 1, 1'b1, 6, 1'b0);
    begin
      int n;
      n = 0;
      while (!psum_enq_en && n < 30) begin
        step();
        n++;
      end
    end
    chk("t5_reach_accum", 32'(psum_enq_en), 1);
    reset = 1'b1;
    step();
    chk("t5_rst_ctrl", 32'({do_load_en, psum_enq_en, iact_write_fin_clear,
        weight_write_fin_clear, psum_spad_clear, busy, done}), 0);
    chk("t5_rst_depth", 32'(PSUM_DEPTH), 0);
    chk("t5_rst_cnts", 32'({weight_pass_cnt, iact_pass_cnt}), 0);
    reset = 1'b0;
    model_en = 1'b0;
    cal_fin = 1'b1;
    psum_add_fin = 1'b1;
    l0 = load_cnt;
    repeat (5) step();
    chk("t5_late_busy", 32'(busy), 0);
    chk("t5_late_loads", load_cnt - l0, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_drain", exp_q.size(), 0);
    cal_fin = 1'b0;
    psum_add_fin = 1'b0;
    model_en = 1'b1;
    add_delay = 4;

    // Stall in WAIT_WR; start pulses and cfg changes must not matter
    all_write_fin = 1'b0;
    d0 = done_cnt;
    start_job(1, 1, 1'b0, 17, 1'b1);
    l0 = load_cnt;
    cfg_psum_depth = 5'd5;
    cfg_weight_passes = 8'd3;
    cfg_accumulate = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      start = ((i % 7) == 3);
    end
    start = 1'b0;
    chk("t6_no_load", load_cnt - l0, 0);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_depth_hold", 32'(PSUM_DEPTH), 17);
    all_write_fin = 1'b1;
    wait_idle(200);
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_drain", exp_q.size(), 0);
    chk("t6_depth_after", 32'(PSUM_DEPTH), 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of pass-count configuration and internal pass counters.
REQ-002 SHALL have ports: clock  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-high; one clock and a synchronous active-high reset, no other clock or async reset.
REQ-004 SHALL have ports: start  input  1  job request, sampled only in IDLE.
REQ-005 SHALL have ports: abort  input  1  forces return to IDLE from any state.
REQ-006 SHALL have ports: cfg_weight_passes  input  CNT_W  weight tiles per iact tile.
REQ-007 SHALL have ports: cfg_iact_passes  input  CNT_W  iact tiles per job.
REQ-008 SHALL have ports: cfg_psum_depth  input  5  psum scratchpad depth for the job.
REQ-009 SHALL have ports: cfg_accumulate  input  1  1 = merge upstream psum after each compute.
REQ-010 SHALL have ports: all_write_fin  input  1  PE reports all four scratchpads written.
REQ-011 SHALL have ports: cal_fin  input  1  PE compute-complete pulse/level.
REQ-012 SHALL have ports: psum_add_fin  input  1  PE psum accumulation complete.
REQ-013 SHALL have ports: do_load_en  output  1  start PE compute.
REQ-014 SHALL have ports: psum_enq_en  output  1  enable PE psum merge.
REQ-015 SHALL have ports: iact_write_fin_clear  output  1  release iact scratchpad status.
REQ-016 SHALL have ports: weight_write_fin_clear  output  1  release weight scratchpad status.
REQ-017 SHALL have ports: psum_spad_clear  output  1  zero PE psum scratchpad.
REQ-018 SHALL have ports: PSUM_DEPTH  output  5  latched cfg_psum_depth.
REQ-019 SHALL have ports: busy  output  1  high in every state except IDLE.
REQ-020 SHALL have ports: done  output  1  one-cycle job-complete pulse.
REQ-021 SHALL have ports: weight_pass_cnt / iact_pass_cnt  output  CNT_W each  current pass indices.

Function
REQ-022 SHALL implement states IDLE, CLEAR, WAIT_WR, LOAD, COMPUTE, ACCUM, RELEASE, DONE in one registered state variable; all control outputs decoded from the current state only.
REQ-023 SHALL, in IDLE with start=1, latch all cfg_* inputs (PSUM_DEPTH updates next cycle) and go to CLEAR; if either latched pass count is 0, go directly to DONE instead.
REQ-024 SHALL ignore start in every state other than IDLE; cfg_* changes after latching have no effect.
REQ-025 SHALL assert psum_spad_clear for exactly one cycle in CLEAR, then go to WAIT_WR.
REQ-026 SHALL hold in WAIT_WR until all_write_fin=1, then go to LOAD; no timeout.
REQ-027 SHALL assert do_load_en for exactly one cycle in LOAD, then go to COMPUTE.
REQ-028 SHALL hold in COMPUTE until cal_fin=1, then go to ACCUM if latched accumulate=1, else to RELEASE.
REQ-029 SHALL assert psum_enq_en continuously in ACCUM until the cycle psum_add_fin=1 is sampled, then go to RELEASE.
REQ-030 SHALL assert weight_write_fin_clear for exactly one cycle in RELEASE.
REQ-031 SHALL, in RELEASE, also assert iact_write_fin_clear in that same cycle when weight_pass_cnt = weight_passes-1.
REQ-032 SHALL, on leaving RELEASE, advance counters:
 - weight_pass_cnt+1 when not last;
 - else weight_pass_cnt to 0 and iact_pass_cnt+1.
REQ-033 SHALL go from RELEASE to DONE when both counters are at their last values; otherwise go to WAIT_WR.
REQ-034 SHALL assert done for one cycle in DONE, clear both counters, then return to IDLE.
REQ-035 SHALL give abort priority over every transition except reset.
REQ-036 SHALL, when abort is sampled in a non-IDLE state, pulse iact_write_fin_clear, weight_write_fin_clear and psum_spad_clear together for one cycle, zero the counters, go to IDLE, and not assert done.
REQ-037 SHALL ignore abort in IDLE.
REQ-038 SHALL ignore cal_fin and psum_add_fin outside COMPUTE and ACCUM respectively; all_write_fin is ignored outside WAIT_WR.
REQ-039 SHALL support counts up to 2^CNT_W-1 with no counter wrap inside a job.

Reset
REQ-040 SHALL, with reset=1 at a clock edge, enter IDLE with counters, PSUM_DEPTH and latched config 0 and all outputs 0, overriding start/abort; reset mid-job discards the job without pulsing done or any clear.

Verification
REQ-041 SHALL verify start with weight=2, iact=1, accumulate=0, all_write_fin tied 1, cal_fin 3 cycles after do_load_en -> 2 do_load_en pulses; 2 weight clears with iact clear only on the second; one done; busy 0 after done.
REQ-042 SHALL verify weight=1, iact=3, accumulate=1, psum_add_fin 4 cycles into ACCUM -> psum_enq_en high exactly 4 cycles per pass, 3 iact clears, iact_pass_cnt sequence 0,1,2.
REQ-043 SHALL verify start with cfg_iact_passes=0 -> no do_load_en, no psum_spad_clear, done pulse within 2 cycles.
REQ-044 SHALL verify abort asserted in COMPUTE -> next cycle all three clears high for one cycle, IDLE, no done; a subsequent start runs normally.
REQ-045 SHALL verify reset asserted in ACCUM -> all outputs 0 next cycle; late psum_add_fin and cal_fin ignored.
REQ-046 SHALL verify all_write_fin held 0 for 50 cycles in WAIT_WR -> no do_load_en; start pulses ignored; cfg_psum_depth=17 at start remains PSUM_DEPTH=17 despite later cfg changes.
